// File: rtl/calc_pkg.sv
// Shared codes for the keypad calculator controller: FSM states, op codes,
// key codes and small nibble helpers.
package calc_pkg;

   typedef enum logic [3:0] {
      ST_A_HI    = 4'd0,
      ST_A_LO    = 4'd1,
      ST_OPSEL   = 4'd2,
      ST_B_HI    = 4'd3,
      ST_B_LO    = 4'd4,
      ST_WAIT_EQ = 4'd5,
      ST_RUN     = 4'd6,
      ST_SHOW    = 4'd7,
      ST_ERR     = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      OP_MUL = 3'd0,
      OP_SUM = 3'd1,
      OP_DIV = 3'd2,
      OP_POW = 3'd3,
      OP_LOG = 3'd4
   } op_e;

   localparam logic [3:0] KEY_ZERO = 4'd10;
   localparam logic [3:0] KEY_MUL  = 4'd11;
   localparam logic [3:0] KEY_CLR  = 4'd14;
   localparam logic [3:0] KEY_LOG  = 4'd15;
   localparam logic [3:0] KEY_EXEC = 4'd15;

   function automatic logic is_digit(input logic [3:0] k);
      return (k != 4'd0) && (k <= KEY_ZERO);
   endfunction

   // The keypad puts digit 0 on code 10.
   function automatic logic [3:0] digit_val(input logic [3:0] k);
      return (k == KEY_ZERO) ? 4'd0 : k;
   endfunction

   function automatic logic [6:0] to_num(input logic [3:0] hi, input logic [3:0] lo);
      return 7'(hi) * 7'd10 + 7'(lo);
   endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad, execution-unit and display signals of the calculator controller.
interface calc_ctrl_if;
   logic [3:0]  usrin;
   logic        exec_done;
   logic [13:0] exec_res;
   logic [6:0]  anum;
   logic [6:0]  bnum;
   logic [2:0]  op;
   logic        exec_start;
   logic [13:0] result;
   logic [3:0]  state;
   logic        err;

   modport master (
      output usrin, exec_done, exec_res,
      input  anum, bnum, op, exec_start, result, state, err
   );

   modport slave (
      input  usrin, exec_done, exec_res,
      output anum, bnum, op, exec_start, result, state, err
   );
endinterface

// File: rtl/key_edge.sv
// Press-edge detector: a key counts only when the previous sample was idle,
// so held keys and key changes without release are ignored.
module key_edge (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_key,
   output logic       o_press
);
   logic [3:0] r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_prev <= 4'd0;
      else       r_prev <= i_key;
   end

   assign o_press = (i_key != 4'd0) && (r_prev == 4'd0);
endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator controller: collects two 2-digit operands and an op,
// launches the execution unit and waits for its result with a timeout.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned TMO_CYC = 255
) (
   input logic        clk,
   input logic        rst,
   calc_ctrl_if.slave bus
);
   // Counter starts at 0 on entry, so the last allowed RUN cycle sees TMO_CYC-1.
   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

   state_e      r_state, w_state_nxt;
   logic [3:0]  r_ahi, r_alo, r_bhi, r_blo;
   logic [3:0]  w_ahi_nxt, w_alo_nxt, w_bhi_nxt, w_blo_nxt;
   op_e         r_op, w_op_nxt;
   logic [13:0] r_result, w_result_nxt;
   logic        r_start, w_start_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        w_press;
   logic [3:0]  w_key;
   logic [6:0]  w_bnum;

   assign w_key  = bus.usrin;
   assign w_bnum = to_num(r_bhi, r_blo);

   key_edge u_key_edge (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_key   (w_key),
      .o_press (w_press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_A_HI;
         r_ahi    <= 4'd0;
         r_alo    <= 4'd0;
         r_bhi    <= 4'd0;
         r_blo    <= 4'd0;
         r_op     <= OP_MUL;
         r_result <= 14'd0;
         r_start  <= 1'b0;
         r_cnt    <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_ahi    <= w_ahi_nxt;
         r_alo    <= w_alo_nxt;
         r_bhi    <= w_bhi_nxt;
         r_blo    <= w_blo_nxt;
         r_op     <= w_op_nxt;
         r_result <= w_result_nxt;
         r_start  <= w_start_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ahi_nxt    = r_ahi;
      w_alo_nxt    = r_alo;
      w_bhi_nxt    = r_bhi;
      w_blo_nxt    = r_blo;
      w_op_nxt     = r_op;
      w_result_nxt = r_result;
      w_start_nxt  = 1'b0;
      w_cnt_nxt    = r_cnt;
      unique case (r_state)
         ST_A_HI: if (w_press && is_digit(w_key)) begin
            w_ahi_nxt   = digit_val(w_key);
            w_state_nxt = ST_A_LO;
         end
         ST_A_LO: if (w_press && is_digit(w_key)) begin
            w_alo_nxt   = digit_val(w_key);
            w_state_nxt = ST_OPSEL;
         end
         ST_OPSEL: if (w_press && (w_key >= KEY_MUL)) begin
            w_op_nxt = op_e'(3'(w_key - KEY_MUL));
            // LOG is unary: skip operand B entirely.
            if (w_key == KEY_LOG) begin
               w_bhi_nxt   = 4'd0;
               w_blo_nxt   = 4'd0;
               w_state_nxt = ST_WAIT_EQ;
            end else begin
               w_state_nxt = ST_B_HI;
            end
         end
         ST_B_HI: if (w_press && is_digit(w_key)) begin
            w_bhi_nxt   = digit_val(w_key);
            w_state_nxt = ST_B_LO;
         end
         ST_B_LO: if (w_press && is_digit(w_key)) begin
            w_blo_nxt   = digit_val(w_key);
            w_state_nxt = ST_WAIT_EQ;
         end
         ST_WAIT_EQ: if (w_press && (w_key == KEY_EXEC)) begin
            if ((r_op == OP_DIV) && (w_bnum == 7'd0)) begin
               w_state_nxt = ST_ERR;
            end else begin
               w_start_nxt = 1'b1;
               w_cnt_nxt   = 8'd0;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = r_cnt + 8'd1;
            if (bus.exec_done) begin
               w_result_nxt = bus.exec_res;
               w_state_nxt  = ST_SHOW;
            end else if (r_cnt == TMO_LAST) begin
               w_state_nxt = ST_ERR;
            end
         end
         ST_SHOW, ST_ERR: if (w_press && (w_key == KEY_CLR)) begin
            w_ahi_nxt    = 4'd0;
            w_alo_nxt    = 4'd0;
            w_bhi_nxt    = 4'd0;
            w_blo_nxt    = 4'd0;
            w_op_nxt     = OP_MUL;
            w_result_nxt = 14'd0;
            w_state_nxt  = ST_A_HI;
         end
         default: w_state_nxt = ST_A_HI;
      endcase
   end

   assign bus.anum       = to_num(r_ahi, r_alo);
   assign bus.bnum       = w_bnum;
   assign bus.op         = r_op;
   assign bus.exec_start = r_start;
   assign bus.result     = r_result;
   assign bus.state      = r_state;
   assign bus.err        = (r_state == ST_ERR);
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter TMO_CYC, default 255, is the maximum cycles to wait for exec_done before timeout (range 1..255).
REQ-002 Port clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port usrin  input  4  keypad code: 0 = no key, 1-9 = digits 1-9, 10 = digit 0, 11-15 = MUL/SUM/DIV/POW/LOG, or command keys per state.
REQ-005 Port exec_done  input  1  one-cycle pulse from the multi-cycle execution unit; result valid in the same cycle.
REQ-006 Port exec_res  input  14  execution-unit result.
REQ-007 Port anum, bnum  output  7 each  operands (tens*10 + units), 0..99.
REQ-008 Port op  output  3  operation code: MUL=0, SUM=1, DIV=2, POW=3, LOG=4.
REQ-009 Port exec_start  output  1  one-cycle start pulse to the execution unit.
REQ-010 Port result  output  14  captured result, held until clear.
REQ-011 Port state  output  4  current FSM state code, for the display mux.
REQ-012 Port err  output  1  high while in state ERR.

Function
REQ-013 A key is accepted only on a press edge: usrin != 0 and the registered previous usrin == 0; held keys and key changes without release are ignored.
REQ-014 FSM states and codes: A_HI=0, A_LO=1, OPSEL=2, B_HI=3, B_LO=4, WAIT_EQ=5, RUN=6, SHOW=7, ERR=8.
REQ-015 A_HI, A_LO, B_HI, B_LO: an accepted digit key (1-10) loads the corresponding nibble (10 loads 0) and advances one state; other keys are ignored.
REQ-016 OPSEL: an accepted key 11-15 sets op (11 -> MUL ... 15 -> LOG) and moves to B_HI; when the key is 15 (LOG), the controller goes directly to WAIT_EQ with bnum = 0.
REQ-017 WAIT_EQ: accepted key 15 = execute; if op = DIV and bnum = 0 -> ERR with no start pulse; otherwise exec_start = 1 for exactly one cycle and -> RUN.
REQ-018 RUN: the timeout counter loads 0 on entry and increments each cycle; exec_done captures exec_res into result and -> SHOW; counter == TMO_CYC without done -> ERR.
REQ-019 exec_done in the same cycle the counter reaches TMO_CYC: done wins, result is captured, -> SHOW.
REQ-020 exec_done outside RUN is ignored; result is unchanged.
REQ-021 SHOW and ERR: accepted key 14 = clear: nibbles, op, and result are set to 0 -> A_HI; other keys are ignored.
REQ-022 Keys are ignored in RUN.
REQ-023 anum/bnum arithmetic is unsigned 7-bit: hi*10 + lo, max 99, no overflow possible.
REQ-024 exec_start latency: asserted in the cycle after the accepted execute key is registered (registered output).

Reset
REQ-025 rst is synchronous and active-high; it has priority over all other inputs in the same cycle.
REQ-026 Reset values: state = A_HI, all nibbles = 0, op = MUL, result = 0, exec_start = 0, err = 0, previous-key register = 0, timeout counter = 0.
REQ-027 rst asserted in RUN aborts the operation; a later exec_done is ignored (REQ-020).

Structure
REQ-028 Op codes, state codes, and key codes (KEY_ZERO=10, KEY_EXEC=15, KEY_CLR=14) live in shared package calc_pkg.
REQ-029 One sub-module, key_edge (press-edge detect of usrin), is instantiated; the FSM and timeout are local.

Verification
REQ-030 Keys 1,2 / 11 / 0x0A,3 / 15 with exec_done after 5 cycles and exec_res=36 -> anum=12, bnum=3, op=MUL, one exec_start pulse, result=36, state=SHOW.
REQ-031 Key 5 held 10 cycles without release -> only A_HI nibble = 5; state = A_LO.
REQ-032 Sequence 4,2 / 13 / 10,10 / 15 -> no exec_start, state=ERR, err=1; then key 14 -> state=A_HI, all outputs 0.
REQ-033 Valid POW execute with no exec_done, TMO_CYC=8 -> ERR exactly 8 cycles after entering RUN.
REQ-034 rst pulsed mid-RUN, then exec_done arrives -> state=A_HI, result=0, no capture.
REQ-035 exec_done coincident with timeout cycle -> SHOW with result captured, err=0.
